alu_rs_issue_scheduler: RTL

Control-plane scheduler for the 8-entry ALU reservation station.
- Tracks per-entry occupancy, source-operand readiness and relative age.
- Wakes entries up from writeback tag broadcasts and selects the oldest ready entry for issue to the ALU over a valid/ready handshake.
- Sits between dispatch (allocation) and the ALU issue port. The RS payload storage is indexed by this block's `alloc_idx` and `issue_idx`.

---
 rtl/types_pkg.sv | 16 +
 rtl/age_matrix_select.sv | 27 ++
 rtl/alu_rs_issue_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared types and constants for the ALU reservation-station scheduler.
package types_pkg;

    localparam int unsigned ALU_RS_DEPTH = 8;
    localparam int unsigned PREG_W       = 8;

    // Per-entry scheduling state; payload lives in a separate RAM indexed by entry number.
    typedef struct packed {
        logic              busy;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
        logic              rdy1;
        logic              rdy2;
    } rs_sched_entry_t;

endpackage

// File: rtl/age_matrix_select.sv
// Oldest-first selector: grants the requester that has no older requester.
module age_matrix_select #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req_i,
    input  logic [DEPTH*DEPTH-1:0]   older_i,  // row i at [i*DEPTH +: DEPTH], bit j = j older than i
    output logic [DEPTH-1:0]         grant_o,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     any_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Grant and encode; the age matrix keeps the grant one-hot so OR-encoding is exact.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant_o[i] = req_i[i] && ((older_i[i*DEPTH +: DEPTH] & req_i) == '0);
            if (grant_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs_issue_scheduler.sv
// Issue scheduler for the ALU reservation station: allocation, wakeup and oldest-ready select.
module alu_rs_issue_scheduler
    import types_pkg::ALU_RS_DEPTH, types_pkg::rs_sched_entry_t;
#(
    parameter int unsigned DEPTH  = ALU_RS_DEPTH,
    parameter int unsigned PREG_W = types_pkg::PREG_W,  // must equal the packaged tag width
    parameter int unsigned NUM_WB = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [PREG_W-1:0]          alloc_pr1,
    input  logic [PREG_W-1:0]          alloc_pr2,
    input  logic                       alloc_pr1_ready,
    input  logic                       alloc_pr2_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]   wb_preg,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [$clog2(DEPTH)-1:0]   issue_idx,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    rs_sched_entry_t          entry_q [DEPTH];
    rs_sched_entry_t          entry_d [DEPTH];
    logic [DEPTH-1:0]         older_q [DEPTH];
    logic [DEPTH-1:0]         older_d [DEPTH];

    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         req;
    logic [DEPTH-1:0]         grant;
    logic [DEPTH*DEPTH-1:0]   older_flat;
    logic [DEPTH-1:0]         wake1;
    logic [DEPTH-1:0]         wake2;
    logic                     free_any;
    logic                     byp1;
    logic                     byp2;
    logic                     alloc_fire;
    logic                     issue_fire;

    // Status derived from registered state only: candidates, free slot and occupancy.
    always_comb begin
        busy       = '0;
        req        = '0;
        older_flat = '0;
        occupancy  = '0;
        alloc_idx  = '0;
        free_any   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy[i]                    = entry_q[i].busy;
            req[i]                     = entry_q[i].busy && entry_q[i].rdy1 && entry_q[i].rdy2;
            older_flat[i*DEPTH +: DEPTH] = older_q[i];
            occupancy                  = occupancy + OCC_W'(entry_q[i].busy);
        end
        // Downward scan so the lowest free index is the last one written.
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IDX_W'(i);
                free_any  = 1'b1;
            end
        end
    end

    age_matrix_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .req_i   (req),
        .older_i (older_flat),
        .grant_o (grant),
        .idx_o   (issue_idx),
        .any_o   (issue_valid)
    );

    assign alloc_ready = free_any && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = issue_valid && issue_ready;

    // Tag match of every writeback port against stored sources and the incoming alloc sources.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        byp1  = alloc_pr1_ready || (alloc_pr1 == '0);
        byp2  = alloc_pr2_ready || (alloc_pr2 == '0);
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wb_preg[p*PREG_W +: PREG_W] == entry_q[i].pr1) wake1[i] = 1'b1;
                    if (wb_preg[p*PREG_W +: PREG_W] == entry_q[i].pr2) wake2[i] = 1'b1;
                end
                if (wb_preg[p*PREG_W +: PREG_W] == alloc_pr1) byp1 = 1'b1;
                if (wb_preg[p*PREG_W +: PREG_W] == alloc_pr2) byp2 = 1'b1;
            end
        end
    end

    // Next state: wakeup, issue clear, allocation with age row, then flush override.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            older_d[i] = older_q[i];
            if (entry_q[i].busy) begin
                if (wake1[i]) entry_d[i].rdy1 = 1'b1;
                if (wake2[i]) entry_d[i].rdy2 = 1'b1;
            end
            if (issue_fire && grant[i]) begin
                entry_d[i].busy = 1'b0;
            end
        end
        if (alloc_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                older_d[i][alloc_idx] = 1'b0;
            end
            entry_d[alloc_idx].busy = 1'b1;
            entry_d[alloc_idx].pr1  = alloc_pr1;
            entry_d[alloc_idx].pr2  = alloc_pr2;
            entry_d[alloc_idx].rdy1 = byp1;
            entry_d[alloc_idx].rdy2 = byp2;
            // Everything still resident after this edge is older than the new entry.
            older_d[alloc_idx]      = busy & ~(issue_fire ? grant : '0);
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_d[i].busy = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule
